alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- 32-bit integer ALU for the single-cycle/pipelined MIPS datapath (execute stage).
- Takes two operands and a 3-bit opcode, and produces a result and an operand-equality flag for branch decisions.
- Outputs are registered: one-cycle latency, qualified by a valid strobe.

Parameters:
- WIDTH, 32, datapath width in bits. Must be even and ≥ 8. LUI shifts by WIDTH/2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/opcode valid this cycle.
- A  input  WIDTH  operand A (rs value).
- B  input  WIDTH  operand B (rt value or extended immediate).
- ALUOp  input  3  operation select.
- C  output  WIDTH  registered result.
- isEqual  output  1  registered flag: 1 when A == B (all bits).
- out_valid  output  1  C/isEqual updated by the previous cycle's in_valid.

Behaviour:
- Reset: reset_n low asynchronously forces C = 0, isEqual = 0, out_valid = 0, and holds them while low. Release is sampled at the next rising clk edge.
- Latency: exactly 1 cycle. Inputs sampled at rising clk when in_valid = 1 appear on C/isEqual after that edge, with out_valid = 1 for one cycle.
- in_valid = 0 at an edge: out_valid <= 0; C and isEqual hold their previous values.
- Back-to-back: in_valid high on consecutive cycles gives a new result every cycle. There is no stall and no backpressure.
- ALUOp decode (result bits, WIDTH wide):
  - 000 ADD: A + B, modulo 2^WIDTH; carry/overflow discarded.
  - 001 SUB: A − B, modulo 2^WIDTH.
  - 010 OR: A | B.
  - 011 AND: A & B.
  - 100 LUI: B << (WIDTH/2), zeros shifted in; A ignored.
  - 101 XOR: A ^ B.
  - 110 SLT: 1 if signed(A) < signed(B), else 0 (zero-extended to WIDTH).
  - 111 SLTU: 1 if unsigned(A) < unsigned(B), else 0.
- isEqual: computed from A and B irrespective of ALUOp, and registered alongside C.
- Edge cases:
  - ADD/SUB wrap silently: 0xFFFFFFFF + 1 = 0; 0 − 1 = 0xFFFFFFFF.
  - SLT with A = 0x80000000, B = 0 → 1. SLTU with the same operands → 0.
  - A == B under SLT/SLTU → 0.
- Reset asserted mid-stream: the in-flight result is discarded. The first out_valid after reset release requires a fresh in_valid.
- No X propagation from unused operands: LUI ignores A entirely.
- All opcode values are defined; there is no illegal opcode.

Test Plan:
- ADD: A=0x00010001, B=60 (0x3C), ALUOp=000, in_valid=1 → next edge: C=0x0001003D, isEqual=0, out_valid=1.
- SUB/equality: A=B=0x12345678, ALUOp=001 → C=0x00000000, isEqual=1. Then A=0, B=1, ALUOp=001 → C=0xFFFFFFFF, isEqual=0.
- Logic/LUI: A=0xF0F0F0F0, B=0x0FF00FF0:
  - ALUOp=010 → C=0xFFF0FFF0.
  - ALUOp=011 → C=0x00F000F0.
  - ALUOp=101 → C=0xFF00FF00.
  - ALUOp=100 with B=0x0000ABCD → C=0xABCD0000.
- Compare: A=0x80000000, B=0x00000001:
  - ALUOp=110 → C=1.
  - ALUOp=111 → C=0.
  - A=B=5 with ALUOp=110 → C=0.
- Valid/hold: in_valid pulses high for one cycle, then low → out_valid high exactly one cycle; C holds its value while in_valid=0 even as A/B change.
- Reset: drive reset_n low asynchronously between clock edges while C≠0 → C=0, isEqual=0, out_valid=0 immediately. After release, no out_valid until in_valid is asserted.

Source files
------------

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// 32-bit (parameterisable) integer ALU for the MIPS execute stage. Operands and
// opcode are sampled on a rising clock edge when in_valid is high; the result
// and an operand-equality flag appear one cycle later, qualified by out_valid.
//
// Parameters:
//   WIDTH      datapath width in bits (even, >= 8); LUI shifts by WIDTH/2
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   A/B/ALUOp valid this cycle
//   A          operand A (rs value)
//   B          operand B (rt value or extended immediate)
//   ALUOp      operation select (ADD, SUB, OR, AND, LUI, XOR, SLT, SLTU)
//   C          registered result
//   isEqual    registered flag, 1 when A == B regardless of ALUOp
//   out_valid  high for one cycle when C/isEqual carry a fresh result
// -----------------------------------------------------------------------------
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    output logic             isEqual,
    output logic             out_valid
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_OR   = 3'b010,
        OP_AND  = 3'b011,
        OP_LUI  = 3'b100,
        OP_XOR  = 3'b101,
        OP_SLT  = 3'b110,
        OP_SLTU = 3'b111
    } alu_op_e;

    localparam int HALF = WIDTH / 2;

    alu_op_e          op;
    logic [WIDTH-1:0] result;
    logic             signed_lt;
    logic             unsigned_lt;

    logic [WIDTH-1:0] c_d,         c_q;
    logic             is_equal_d,  is_equal_q;
    logic             out_valid_d, out_valid_q;

    assign op          = alu_op_e'(ALUOp);
    assign signed_lt   = $signed(A) < $signed(B);
    assign unsigned_lt = A < B;

    // Combinational result. Every opcode is defined, so the default arm only
    // exists to keep the decode total. LUI never looks at A.
    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = A + B;
            OP_SUB:  result = A - B;
            OP_OR:   result = A | B;
            OP_AND:  result = A & B;
            OP_LUI:  result = {B[HALF-1:0], {HALF{1'b0}}};
            OP_XOR:  result = A ^ B;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, signed_lt};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, unsigned_lt};
            default: result = '0;
        endcase
    end

    // Result and flag only load on an accepted input; otherwise they hold so
    // downstream logic can keep reading the last result while idle.
    always_comb begin
        c_d         = c_q;
        is_equal_d  = is_equal_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            c_d        = result;
            is_equal_d = (A == B);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_q         <= '0;
            is_equal_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            is_equal_q  <= is_equal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign C         = c_q;
    assign isEqual   = is_equal_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_unit
// Scoreboard bench for alu_unit: stimulus pushes expected results into a queue
// and a monitor pops/compares whenever out_valid is seen. Idle-hold and reset
// behaviour are checked directly from the main flow.
// -----------------------------------------------------------------------------
module tb_alu_unit;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] c;
        logic         eq;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [2:0]   alu_op = '0;
    logic [W-1:0] c_out;
    logic         is_equal;
    logic         out_valid;

    exp_t         exp_q[$];
    int           n_compared = 0;
    int           n_mismatched = 0;
    logic [W-1:0] last_c = '0;
    logic         last_eq = 1'b0;
    logic         last_drive_valid = 1'b0;

    alu_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .A        (a_in),
        .B        (b_in),
        .ALUOp    (alu_op),
        .C        (c_out),
        .isEqual  (is_equal),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference model computed with 64-bit arithmetic and explicit modulo.
    function automatic logic [W-1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] op);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned m  = 64'h1_0000_0000;
        longint unsigned r;
        case (op)
            3'd0:    r = (ua + ub) % m;
            3'd1:    r = (ua + m - ub) % m;
            3'd2:    r = ua | ub;
            3'd3:    r = ua & ub;
            3'd4:    r = (ub * 65536) % m;
            3'd5:    r = ua ^ ub;
            3'd6:    r = (sa < sb) ? 1 : 0;
            default: r = (ua < ub) ? 1 : 0;
        endcase
        return r[W-1:0];
    endfunction

    function automatic void compare(input string name, input logic [W-1:0] act,
                                    input logic [W-1:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endfunction

    // Drive one accepted transaction and record its expected response.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input string name);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        alu_op   = op;
        e.c      = refModel(a, b, op);
        e.eq     = (a == b);
        e.name   = name;
        exp_q.push_back(e);
        last_c   = e.c;
        last_eq  = e.eq;
        last_drive_valid = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] c_req,
                               input logic eq_req, input logic v_req);
        compare({name, ".C"}, c_out, c_req);
        compare({name, ".isEqual"}, {{(W-1){1'b0}}, is_equal}, {{(W-1){1'b0}}, eq_req});
        compare({name, ".out_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, v_req});
    endtask

    // Idle cycles with scrambled operands; once the previous result has been
    // presented, outputs must hold with out_valid low.
    task automatic idleCycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!last_drive_valid)
                checkOutput(name, last_c, last_eq, 1'b0);
            in_valid = 1'b0;
            a_in     = $urandom;
            b_in     = $urandom;
            alu_op   = 3'($urandom_range(0, 7));
            last_drive_valid = 1'b0;
        end
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_out_valid: got out_valid=1 expected 0 (C=0x%08h)", c_out);
            end else begin
                e = exp_q.pop_front();
                compare({e.name, ".C"}, c_out, e.c);
                compare({e.name, ".isEqual"}, {{(W-1){1'b0}}, is_equal}, {{(W-1){1'b0}}, e.eq});
            end
        end
    end

    initial begin
        $display("[TB] alu_unit scoreboard test starting");
        #2;
        checkOutput("reset_initial", '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Directed vectors
        applyStimulus(32'h0001_0001, 32'h0000_003C, 3'b000, "add");
        applyStimulus(32'h1234_5678, 32'h1234_5678, 3'b001, "sub_equal");
        applyStimulus(32'h0000_0000, 32'h0000_0001, 3'b001, "sub_wrap");
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, "add_wrap");
        applyStimulus(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, "or");
        applyStimulus(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, "and");
        applyStimulus(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b101, "xor");
        applyStimulus(32'hDEAD_BEEF, 32'h0000_ABCD, 3'b100, "lui");
        applyStimulus(32'h8000_0000, 32'h0000_0001, 3'b110, "slt_neg");
        applyStimulus(32'h8000_0000, 32'h0000_0001, 3'b111, "sltu_big");
        applyStimulus(32'h8000_0000, 32'h0000_0000, 3'b110, "slt_min_zero");
        applyStimulus(32'h8000_0000, 32'h0000_0000, 3'b111, "sltu_min_zero");
        applyStimulus(32'h0000_0005, 32'h0000_0005, 3'b110, "slt_equal");
        applyStimulus(32'h0000_0005, 32'h0000_0005, 3'b111, "sltu_equal");

        // Single pulse then hold while operands change
        idleCycles(1, "hold_a");
        applyStimulus(32'h0000_1111, 32'h0000_2222, 3'b000, "pulse_add");
        idleCycles(4, "hold_b");

        // Reset between edges while a non-zero result is being presented
        applyStimulus(32'h1357_9BDF, 32'h0246_8ACE, 3'b000, "pre_reset");
        @(posedge clk);
        #3 reset_n = 1'b0;
        exp_q.delete();
        last_c  = '0;
        last_eq = 1'b0;
        #1 checkOutput("reset_async", '0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("reset_held", '0, 1'b0, 1'b0);
        in_valid = 1'b0;
        last_drive_valid = 1'b0;
        #2 reset_n = 1'b1;
        idleCycles(3, "post_reset_idle");
        applyStimulus(32'h0000_0007, 32'h0000_0007, 3'b011, "post_reset_first");

        // Randomised traffic with back-to-back bursts and gaps
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) != 0)
                applyStimulus(ra, rb, 3'($urandom_range(0, 7)), "rand");
            else
                idleCycles(1, "rand_idle");
        end

        idleCycles(3, "drain");
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL missing_outputs: got %0d outstanding expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
